// File: rtl/decode_hazard_ctrl.sv
// Decode-stage operand bypass and hazard control: N-source forwarding with load-use
// detection, a multi-cycle multiplier scoreboard and LL/SC link tracking.
module decode_hazard_ctrl #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2,
    parameter int MUL_LAT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_AW-1:0]         rs_addr,
    input  logic [REG_AW-1:0]         rt_addr,
    input  logic                      rs_used,
    input  logic                      rt_used,
    input  logic [DATA_W-1:0]         rs_data_in,
    input  logic [DATA_W-1:0]         rt_data_in,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_is_load,
    input  logic                      issue_valid,
    input  logic                      mul_issue,
    input  logic [REG_AW-1:0]         mul_dest,
    input  logic                      ll_issue,
    input  logic                      sc_issue,
    input  logic                      store_issue,
    input  logic                      flush,
    output logic [DATA_W-1:0]         rs_data,
    output logic [DATA_W-1:0]         rt_data,
    output logic                      stall,
    output logic                      mul_busy,
    output logic                      mul_done,
    output logic                      atomic_id,
    output logic                      mem_sc_mask_id
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0]  fwd_data_arr [NUM_FWD];
    logic [NUM_FWD-1:0] rs_match;
    logic [NUM_FWD-1:0] rt_match;

    logic               rs_pend;
    logic               rt_pend;
    logic               load_use_rs;
    logic               load_use_rt;
    logic               mul_hazard;
    logic               accept;

    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic [REG_AW-1:0]  mul_dest_reg;
    logic [REG_AW-1:0]  mul_dest_next;
    logic               mul_done_reg;
    logic               link_reg;
    logic               link_next;

    // Per-source match vectors; register 0 never matches so it always reads the regfile.
    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd
            assign fwd_data_arr[gi] = fwd_data[gi*DATA_W +: DATA_W];
            assign rs_match[gi] = fwd_we[gi] && (fwd_addr[gi*REG_AW +: REG_AW] == rs_addr)
                                  && (rs_addr != '0);
            assign rt_match[gi] = fwd_we[gi] && (fwd_addr[gi*REG_AW +: REG_AW] == rt_addr)
                                  && (rt_addr != '0);
        end
    endgenerate

    // Walk from oldest to youngest so the lowest matching index has the final say;
    // a pending-load winner masks whatever older sources said.
    always_comb begin
        rs_data = rs_data_in;
        rs_pend = 1'b0;
        rt_data = rt_data_in;
        rt_pend = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (rs_match[i]) begin
                rs_data = fwd_is_load[i] ? rs_data_in : fwd_data_arr[i];
                rs_pend = fwd_is_load[i];
            end
            if (rt_match[i]) begin
                rt_data = fwd_is_load[i] ? rt_data_in : fwd_data_arr[i];
                rt_pend = fwd_is_load[i];
            end
        end
    end

    assign load_use_rs = rs_pend & rs_used;
    assign load_use_rt = rt_pend & rt_used;

    assign mul_busy   = (cnt_reg != '0);
    assign mul_hazard = mul_busy & (mul_issue
                        | (rs_used & (rs_addr == mul_dest_reg) & (rs_addr != '0))
                        | (rt_used & (rt_addr == mul_dest_reg) & (rt_addr != '0)));

    assign stall  = issue_valid & (load_use_rs | load_use_rt | mul_hazard);
    assign accept = issue_valid & ~stall & ~flush;

    // A flush only squashes the decode instruction; an in-flight multiply keeps counting.
    always_comb begin
        cnt_next      = cnt_reg;
        mul_dest_next = mul_dest_reg;
        if (accept && mul_issue) begin
            cnt_next      = CNT_LOAD;
            mul_dest_next = mul_dest;
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_ONE;
        end
    end

    always_comb begin
        link_next = link_reg;
        if (flush) begin
            link_next = 1'b0;
        end else if (accept && ll_issue) begin
            link_next = 1'b1;
        end else if (accept && (sc_issue || store_issue)) begin
            link_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            mul_dest_reg <= '0;
            mul_done_reg <= 1'b0;
            link_reg     <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            mul_dest_reg <= mul_dest_next;
            mul_done_reg <= (cnt_reg == CNT_ONE);
            link_reg     <= link_next;
        end
    end

    assign mul_done       = mul_done_reg;
    assign atomic_id      = link_reg;
    assign mem_sc_mask_id = sc_issue & ~link_reg;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Scoreboard bench for decode_hazard_ctrl: each cycle's expected output bundle is queued
// when stimulus is applied and compared against the DUT on the following falling edge.
module tb_decode_hazard_ctrl;

    localparam logic [31:0] RSIN = 32'h0000_1111;
    localparam logic [31:0] RTIN = 32'h0000_2222;
    localparam logic [31:0] D0   = 32'h0000_AAAA;
    localparam logic [31:0] D1   = 32'h0000_BBBB;

    // {rs_data, rt_data, stall, mul_busy, mul_done, atomic_id, mem_sc_mask_id}
    typedef logic [68:0] out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr;
    logic        rs_used, rt_used;
    logic [31:0] rs_data_in, rt_data_in;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic [1:0]  fwd_is_load;
    logic        issue_valid, mul_issue;
    logic [4:0]  mul_dest;
    logic        ll_issue, sc_issue, store_issue, flush;
    logic [31:0] rs_data, rt_data;
    logic        stall, mul_busy, mul_done, atomic_id, mem_sc_mask_id;

    int   checks   = 0;
    int   failures = 0;
    out_t exp_q[$];
    string tag_q[$];

    decode_hazard_ctrl #(.DATA_W(32), .REG_AW(5), .NUM_FWD(2), .MUL_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
        .rs_data_in(rs_data_in), .rt_data_in(rt_data_in),
        .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_is_load(fwd_is_load),
        .issue_valid(issue_valid), .mul_issue(mul_issue), .mul_dest(mul_dest),
        .ll_issue(ll_issue), .sc_issue(sc_issue), .store_issue(store_issue), .flush(flush),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .mul_busy(mul_busy),
        .mul_done(mul_done), .atomic_id(atomic_id), .mem_sc_mask_id(mem_sc_mask_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic out_t mk(logic [31:0] rs, logic [31:0] rt, logic st, logic bz,
                                logic dn, logic at, logic mk_bit);
        return {rs, rt, st, bz, dn, at, mk_bit};
    endfunction

    task automatic idle();
        rst = 1'b0; rs_addr = '0; rt_addr = '0; rs_used = 1'b0; rt_used = 1'b0;
        rs_data_in = RSIN; rt_data_in = RTIN;
        fwd_we = '0; fwd_addr = '0; fwd_data = {D1, D0}; fwd_is_load = '0;
        issue_valid = 1'b0; mul_issue = 1'b0; mul_dest = '0;
        ll_issue = 1'b0; sc_issue = 1'b0; store_issue = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        out_t got, want;
        string tag;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            idle();
            rst = (c == 0);
            exp_q.push_back(mk(RSIN, RTIN, 0, 0, 0, 0, 0));
            tag_q.push_back($sformatf("test_reset c%0d", c));
            @(negedge clk);
            got = {rs_data, rt_data, stall, mul_busy, mul_done, atomic_id, mem_sc_mask_id};
            want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: got %h want %h", tag, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fwd_priority();
        out_t got, want;
        string tag;
        for (int c = 0; c < 6; c++) begin
            idle();
            issue_valid = 1'b1; rs_used = 1'b1; fwd_we = 2'b11;
            fwd_addr = {5'd5, 5'd5}; rs_addr = 5'd5;
            case (c)
                0: want = mk(D0, RTIN, 0, 0, 0, 0, 0);
                1: begin rs_addr = 5'd0; want = mk(RSIN, RTIN, 0, 0, 0, 0, 0); end
                2: begin fwd_we = 2'b10; want = mk(D1, RTIN, 0, 0, 0, 0, 0); end
                3: begin
                    fwd_addr = {5'd5, 5'd6}; rt_addr = 5'd6; rt_used = 1'b1;
                    want = mk(D1, D0, 0, 0, 0, 0, 0);
                end
                4: begin fwd_we = 2'b00; rt_addr = 5'd5; want = mk(RSIN, RTIN, 0, 0, 0, 0, 0); end
                default: begin
                    fwd_addr = '0; rs_addr = '0; rt_addr = '0;
                    want = mk(RSIN, RTIN, 0, 0, 0, 0, 0);
                end
            endcase
            exp_q.push_back(want);
            tag_q.push_back($sformatf("test_fwd_priority c%0d", c));
            @(negedge clk);
            got = {rs_data, rt_data, stall, mul_busy, mul_done, atomic_id, mem_sc_mask_id};
            want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: got %h want %h", tag, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        out_t got, want;
        string tag;
        for (int c = 0; c < 7; c++) begin
            idle();
            issue_valid = 1'b1; fwd_we = 2'b11; fwd_is_load = 2'b01;
            fwd_addr = {5'd3, 5'd7}; rt_addr = 5'd7; rt_used = 1'b1;
            case (c)
                0: want = mk(RSIN, RTIN, 1, 0, 0, 0, 0);
                1: begin rt_used = 1'b0; want = mk(RSIN, RTIN, 0, 0, 0, 0, 0); end
                2: begin fwd_addr = {5'd7, 5'd7}; want = mk(RSIN, RTIN, 1, 0, 0, 0, 0); end
                3: begin
                    fwd_addr = {5'd7, 5'd7}; fwd_is_load = 2'b10;
                    want = mk(RSIN, D0, 0, 0, 0, 0, 0);
                end
                4: begin issue_valid = 1'b0; want = mk(RSIN, RTIN, 0, 0, 0, 0, 0); end
                5: begin
                    fwd_addr = {5'd3, 5'd0}; rt_addr = '0; rs_addr = '0; rs_used = 1'b1;
                    want = mk(RSIN, RTIN, 0, 0, 0, 0, 0);
                end
                default: begin
                    rt_addr = '0; rt_used = 1'b0; rs_addr = 5'd7; rs_used = 1'b1;
                    want = mk(RSIN, RTIN, 1, 0, 0, 0, 0);
                end
            endcase
            exp_q.push_back(want);
            tag_q.push_back($sformatf("test_load_use c%0d", c));
            @(negedge clk);
            got = {rs_data, rt_data, stall, mul_busy, mul_done, atomic_id, mem_sc_mask_id};
            want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: got %h want %h", tag, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mul();
        out_t got, want;
        string tag;
        for (int c = 0; c < 9; c++) begin
            idle();
            case (c)
                0: begin
                    issue_valid = 1'b1; mul_issue = 1'b1; mul_dest = 5'd9;
                    want = mk(RSIN, RTIN, 0, 0, 0, 0, 0);
                end
                1: begin
                    issue_valid = 1'b1; rs_addr = 5'd3; rs_used = 1'b1;
                    want = mk(RSIN, RTIN, 0, 1, 0, 0, 0);
                end
                2, 3: begin
                    issue_valid = 1'b1; rs_addr = 5'd9; rs_used = 1'b1;
                    want = mk(RSIN, RTIN, 1, 1, 0, 0, 0);
                end
                4: begin
                    issue_valid = 1'b1; rt_addr = 5'd9; rt_used = 1'b1;
                    want = mk(RSIN, RTIN, 1, 1, 0, 0, 0);
                end
                5: begin
                    issue_valid = 1'b1; rs_addr = 5'd9; rs_used = 1'b1;
                    want = mk(RSIN, RTIN, 0, 0, 1, 0, 0);
                end
                7: begin
                    issue_valid = 1'b1; mul_issue = 1'b1; mul_dest = 5'd4; flush = 1'b1;
                    want = mk(RSIN, RTIN, 0, 0, 0, 0, 0);
                end
                default: want = mk(RSIN, RTIN, 0, 0, 0, 0, 0);
            endcase
            exp_q.push_back(want);
            tag_q.push_back($sformatf("test_mul c%0d", c));
            @(negedge clk);
            got = {rs_data, rt_data, stall, mul_busy, mul_done, atomic_id, mem_sc_mask_id};
            want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: got %h want %h", tag, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        out_t got, want;
        string tag;
        for (int c = 0; c < 12; c++) begin
            idle();
            if (c <= 5) begin
                issue_valid = 1'b1; mul_issue = 1'b1; mul_dest = 5'd10;
            end
            case (c)
                0: want = mk(RSIN, RTIN, 0, 0, 0, 0, 0);
                1, 2, 3, 4: begin
                    flush = (c == 2);
                    want = mk(RSIN, RTIN, 1, 1, 0, 0, 0);
                end
                5: want = mk(RSIN, RTIN, 0, 0, 1, 0, 0);
                6, 7, 8, 9: want = mk(RSIN, RTIN, 0, 1, 0, 0, 0);
                10: want = mk(RSIN, RTIN, 0, 0, 1, 0, 0);
                default: want = mk(RSIN, RTIN, 0, 0, 0, 0, 0);
            endcase
            exp_q.push_back(want);
            tag_q.push_back($sformatf("test_back_to_back c%0d", c));
            @(negedge clk);
            got = {rs_data, rt_data, stall, mul_busy, mul_done, atomic_id, mem_sc_mask_id};
            want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: got %h want %h", tag, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_llsc();
        out_t got, want;
        string tag;
        for (int c = 0; c < 15; c++) begin
            idle();
            issue_valid = 1'b1;
            case (c)
                0:  begin ll_issue = 1'b1;    want = mk(RSIN, RTIN, 0, 0, 0, 0, 0); end
                1:  begin sc_issue = 1'b1;    want = mk(RSIN, RTIN, 0, 0, 0, 1, 0); end
                2:  begin sc_issue = 1'b1;    want = mk(RSIN, RTIN, 0, 0, 0, 0, 1); end
                3:  begin ll_issue = 1'b1;    want = mk(RSIN, RTIN, 0, 0, 0, 0, 0); end
                4:  begin store_issue = 1'b1; want = mk(RSIN, RTIN, 0, 0, 0, 1, 0); end
                5:  begin sc_issue = 1'b1;    want = mk(RSIN, RTIN, 0, 0, 0, 0, 1); end
                6:  begin ll_issue = 1'b1;    want = mk(RSIN, RTIN, 0, 0, 0, 0, 0); end
                7:  begin issue_valid = 1'b0; want = mk(RSIN, RTIN, 0, 0, 0, 1, 0); end
                8:  begin
                    ll_issue = 1'b1; flush = 1'b1;
                    want = mk(RSIN, RTIN, 0, 0, 0, 1, 0);
                end
                9:  begin issue_valid = 1'b0; want = mk(RSIN, RTIN, 0, 0, 0, 0, 0); end
                10: begin ll_issue = 1'b1;    want = mk(RSIN, RTIN, 0, 0, 0, 0, 0); end
                11: begin
                    sc_issue = 1'b1; fwd_we = 2'b01; fwd_is_load = 2'b01;
                    fwd_addr = {5'd0, 5'd7}; rs_addr = 5'd7; rs_used = 1'b1;
                    want = mk(RSIN, RTIN, 1, 0, 0, 1, 0);
                end
                12: begin issue_valid = 1'b0; want = mk(RSIN, RTIN, 0, 0, 0, 1, 0); end
                13: begin
                    issue_valid = 1'b0; sc_issue = 1'b1;
                    want = mk(RSIN, RTIN, 0, 0, 0, 1, 0);
                end
                default: begin issue_valid = 1'b0; want = mk(RSIN, RTIN, 0, 0, 0, 1, 0); end
            endcase
            exp_q.push_back(want);
            tag_q.push_back($sformatf("test_llsc c%0d", c));
            @(negedge clk);
            got = {rs_data, rt_data, stall, mul_busy, mul_done, atomic_id, mem_sc_mask_id};
            want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: got %h want %h", tag, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    // Entered with the link still held from test_llsc.
    task automatic test_reset_mid();
        out_t got, want;
        string tag;
        for (int c = 0; c < 8; c++) begin
            idle();
            case (c)
                0: begin
                    issue_valid = 1'b1; mul_issue = 1'b1; mul_dest = 5'd9;
                    want = mk(RSIN, RTIN, 0, 0, 0, 1, 0);
                end
                1, 2: want = mk(RSIN, RTIN, 0, 1, 0, 1, 0);
                3: begin rst = 1'b1; want = mk(RSIN, RTIN, 0, 1, 0, 1, 0); end
                default: want = mk(RSIN, RTIN, 0, 0, 0, 0, 0);
            endcase
            exp_q.push_back(want);
            tag_q.push_back($sformatf("test_reset_mid c%0d", c));
            @(negedge clk);
            got = {rs_data, rt_data, stall, mul_busy, mul_done, atomic_id, mem_sc_mask_id};
            want = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: got %h want %h", tag, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_mul();
        test_back_to_back();
        test_llsc();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
